// File: rtl/axi_ad9162_dac_buffer.sv
// Elastic prefill buffer between the DMA stream and the AD9162 DAC core (dac_clk domain).
// Optional underflow counter port unf_count: define AXI_AD9162_DAC_BUFFER_UNF_COUNT_EN.
module axi_ad9162_dac_buffer #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned PREFILL    = 8
) (
  input  logic                  dac_clk,
  input  logic                  dac_rstn,
  input  logic                  dac_enable,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  input  logic                  dac_valid,
  output logic [DATA_WIDTH-1:0] dac_ddata,
  output logic                  dac_dunf,
  output logic [ADDR_WIDTH:0]   fifo_level,
  output logic                  prefilled
`ifdef AXI_AD9162_DAC_BUFFER_UNF_COUNT_EN
  ,
  output logic [31:0]           unf_count
`endif
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned LW    = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]           level_q, level_d;
  logic [DATA_WIDTH-1:0]   ddata_q, ddata_d;
  logic                    dunf_q, dunf_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    wr_en;
  logic                    rd_en;
  logic                    unf_ev;
  logic                    run;

  // Level (not pointer equality) decides full/empty, so a full FIFO is never seen as empty.
  assign s_ready = dac_rstn & dac_enable & (level_q != LW'(DEPTH));
  assign wr_en   = s_valid & s_ready;
  assign run     = dac_enable & (state_q == ST_RUN);
  assign rd_en   = run & dac_valid & (level_q != '0);
  assign unf_ev  = run & dac_valid & (level_q == '0);

  // Next-state: prefill gate on registered level, enable low forces idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    state_d = ST_PREFILL;
      ST_PREFILL: if (level_q >= LW'(PREFILL)) state_d = ST_RUN;
      ST_RUN:     state_d = ST_RUN;
      default:    state_d = ST_IDLE;
    endcase
    if (!dac_enable) state_d = ST_IDLE;
  end

  // Pointers, occupancy and the registered core-side output word.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ddata_d  = ddata_q;
    dunf_d   = unf_ev;

    if (wr_en) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);

    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (state_q != ST_RUN) begin
      ddata_d = '0;
    end else if (rd_en) begin
      ddata_d = mem_q[rd_ptr_q];
    end else if (unf_ev) begin
      ddata_d = '0;
    end

    if (!dac_enable) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ddata_d  = '0;
      dunf_d   = 1'b0;
    end
  end

  always_ff @(posedge dac_clk) begin
    if (!dac_rstn) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ddata_q  <= '0;
      dunf_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ddata_q  <= ddata_d;
      dunf_q   <= dunf_d;
    end
  end

  // Storage array carries no reset; contents are only read behind a valid level.
  always_ff @(posedge dac_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= s_data;
  end

  assign dac_ddata  = ddata_q;
  assign dac_dunf   = dunf_q;
  assign fifo_level = level_q;
  assign prefilled  = (state_q == ST_RUN);

`ifdef AXI_AD9162_DAC_BUFFER_UNF_COUNT_EN
  logic [31:0] unf_count_q, unf_count_d;

  // Saturating count of missed requests, cleared whenever the channel idles.
  always_comb begin
    unf_count_d = unf_count_q;
    if (unf_ev && (unf_count_q != 32'hFFFF_FFFF)) unf_count_d = unf_count_q + 32'd1;
    if (!dac_enable) unf_count_d = '0;
  end

  always_ff @(posedge dac_clk) begin
    if (!dac_rstn) unf_count_q <= '0;
    else           unf_count_q <= unf_count_d;
  end

  assign unf_count = unf_count_q;
`endif

endmodule
